// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache: funct3 codes, FSM states,
// and the RV32I byte-enable and load-extension helpers.
package dcache_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, REFILL, RESP, WRITE} state_t;

    function automatic logic req_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (we) begin
            case (f3)
                F3_SB:   ok = 1'b1;
                F3_SH:   ok = !off[0];
                F3_SW:   ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: ok = 1'b1;
                F3_LH, F3_LHU: ok = !off[0];
                F3_LW:         ok = (off == 2'b00);
                default:       ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_SB:   be = 4'b0001 << off;
            F3_SH:   be = off[1] ? 4'b1100 : 4'b0011;
            F3_SW:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Shift the addressed lane down to bit 0, then extend according to funct3.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] w,
                                                input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] res;
        sh = w >> {off, 3'b000};
        case (f3)
            F3_LB:   res = {{24{sh[7]}}, sh[7:0]};
            F3_LH:   res = {{16{sh[15]}}, sh[15:0]};
            F3_LW:   res = sh;
            F3_LBU:  res = {24'b0, sh[7:0]};
            F3_LHU:  res = {16'b0, sh[15:0]};
            default: res = 32'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dcache_store_merge.sv
// Store lane placement: replicates the right-aligned store data into every lane
// and merges the enabled lanes into an existing word.
module dcache_store_merge
    import dcache_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic [31:0] old_word,
    output logic [31:0] lanes,
    output logic [31:0] merged
);

    always_comb begin
        case (funct3)
            F3_SB:   lanes = {4{wdata[7:0]}};
            F3_SH:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = lanes[8*i +: 8];
        end
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of a word memory.
// Optional DCACHE_STATS_EN adds hit/miss/store counters as extra outputs.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           store_count
`endif
);

    localparam int WB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TB = DATA_WIDTH - 2 - WB - IB;

    state_t                state;
    logic [WB-1:0]         beat;
    logic [WB-1:0]         next_beat;
    logic [DATA_WIDTH-1:0] lat_addr;
    logic [2:0]            lat_funct3;
    logic [SETS-1:0]       valid;
    logic [TB-1:0]         tag_arr  [SETS];
    logic [DATA_WIDTH-1:0] data_arr [SETS*LINE_WORDS];

    logic [WB-1:0] req_word, lat_word;
    logic [IB-1:0] req_idx, lat_idx;
    logic [TB-1:0] req_tag, lat_tag;
    logic          accept, legal, hit, last_beat;
    logic [3:0]    req_be;
    logic [DATA_WIDTH-1:0] cur_word, lanes, merged;

    assign req_word  = req_addr[2 +: WB];
    assign req_idx   = req_addr[2+WB +: IB];
    assign req_tag   = req_addr[DATA_WIDTH-1 -: TB];
    assign lat_word  = lat_addr[2 +: WB];
    assign lat_idx   = lat_addr[2+WB +: IB];
    assign lat_tag   = lat_addr[DATA_WIDTH-1 -: TB];

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign legal     = req_legal(req_we, req_funct3, req_addr[1:0]);
    assign hit       = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign cur_word  = data_arr[{req_idx, req_word}];
    assign req_be    = byte_en(req_funct3, req_addr[1:0]);
    assign next_beat = beat + 1'b1;
    assign last_beat = (beat == WB'(LINE_WORDS - 1));

    dcache_store_merge u_merge (
        .funct3   (req_funct3),
        .wdata    (req_wdata),
        .be       (req_be),
        .old_word (cur_word),
        .lanes    (lanes),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            beat       <= '0;
            lat_addr   <= '0;
            lat_funct3 <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    lat_addr   <= req_addr;
                    lat_funct3 <= req_funct3;
                    if (!legal) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else if (req_we) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {req_addr[DATA_WIDTH-1:2], 2'b00};
                        mem_wdata <= lanes;
                        mem_be    <= req_be;
                    end else if (hit) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_extend(req_funct3, cur_word, req_addr[1:0]);
                    end else begin
                        state    <= REFILL;
                        beat     <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_be   <= 4'hF;
                        mem_addr <= {req_tag, req_idx, {WB{1'b0}}, 2'b00};
                    end
                end
                REFILL: if (mem_ready) begin
                    if (last_beat) begin
                        valid[lat_idx] <= 1'b1;
                        mem_req        <= 1'b0;
                        state          <= RESP;
                    end else begin
                        beat     <= next_beat;
                        mem_addr <= {lat_tag, lat_idx, next_beat, 2'b00};
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= load_extend(lat_funct3, data_arr[{lat_idx, lat_word}], lat_addr[1:0]);
                    state     <= IDLE;
                end
                WRITE: if (mem_ready) begin
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage arrays carry no reset; the valid vector alone decides what is cached.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept && legal && req_we && hit)
                data_arr[{req_idx, req_word}] <= merged;
            if (state == REFILL && mem_ready) begin
                data_arr[{lat_idx, beat}] <= mem_rdata;
                if (last_beat) tag_arr[lat_idx] <= lat_tag;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count   <= '0;
            miss_count  <= '0;
            store_count <= '0;
        end else if (accept && legal) begin
            if (req_we)   store_count <= store_count + 1'b1;
            else if (hit) hit_count   <= hit_count + 1'b1;
            else          miss_count  <= miss_count + 1'b1;
        end
    end
`endif

endmodule
